// File: rtl/rv_plic_pkg.sv
// Shared types and defaults for the PLIC interrupt gateway stage.
// Holds the gateway FSM encoding and default sizing constants.
package rv_plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'b00,
    GW_PENDING = 2'b01,
    GW_ACTIVE  = 2'b10
  } gw_state_e;

  localparam int unsigned N_SOURCE_DEF    = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/rv_plic_gateway_cell.sv
// Single-source PLIC gateway: synchronizer, edge detect, claim/complete
// FSM and saturating queue of edges seen while the source is busy.
module rv_plic_gateway_cell
  import rv_plic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s;
  logic             s_q;
  logic             edge_det;
  logic             cnt_nz;
  logic             req;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gw_state_e        state_q, state_d;
  logic             ip_q;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  assign edge_det = s & ~s_q;
  assign cnt_nz   = |cnt_q;
  assign req      = le_i ? (edge_det | cnt_nz) : s;

  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    unique case (state_q)
      GW_IDLE: begin
        if (req) begin
          state_d = GW_PENDING;
          // a queued edge is consumed only when no fresh edge drove req
          dec     = le_i & ~edge_det & cnt_nz;
        end
      end
      GW_PENDING: if (claim_i)    state_d = GW_ACTIVE;
      GW_ACTIVE:  if (complete_i) state_d = GW_IDLE;
      default:    state_d = GW_IDLE;
    endcase
  end

  assign inc = le_i & (state_q != GW_IDLE) & edge_det
             & (cnt_q != CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!le_i) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= 1'b0;
      cnt_q   <= '0;
      state_q <= GW_IDLE;
      ip_q    <= 1'b0;
    end else begin
      s_q     <= s;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ip_q    <= (state_d == GW_PENDING);
    end
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/rv_plic_gateway_array.sv
// PLIC gateway array: one gateway cell per interrupt source, producing
// the registered pending vector for the target arbiter.
module rv_plic_gateway_array
  import rv_plic_pkg::*;
#(
  parameter int unsigned N_SOURCE    = N_SOURCE_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  output logic [N_SOURCE-1:0] ip_o
);

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
    rv_plic_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .src_i      (src_i[i]),
      .le_i       (le_i[i]),
      .claim_i    (claim_i[i]),
      .complete_i (complete_i[i]),
      .ip_o       (ip_o[i])
    );
  end

endmodule

// File: tb/tb_rv_plic_gateway_array.sv
// Bench for the PLIC gateway array: vector tables with an expected-value
// queue, plus hand sequences for reset and arbiter integration.
module tb_rv_plic_gateway_array;

  typedef struct {
    logic [31:0] src;
    logic [31:0] le;
    logic [31:0] cl;
    logic [31:0] co;
    logic [31:0] exp;
    bit          sm;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] src, le, claim, comp;
  logic [31:0] ip;
  logic [3:0]  ip_sm;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          prio[32];

  rv_plic_gateway_array u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
    .le_i       (le),
    .claim_i    (claim),
    .complete_i (comp),
    .ip_o       (ip)
  );

  rv_plic_gateway_array #(
    .N_SOURCE    (4),
    .SYNC_STAGES (2),
    .CNT_W       (2)
  ) u_sm (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src[3:0]),
    .le_i       (le[3:0]),
    .claim_i    (claim[3:0]),
    .complete_i (comp[3:0]),
    .ip_o       (ip_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] s, input logic [31:0] l,
                              input logic [31:0] c, input logic [31:0] o,
                              input logic [31:0] e, input bit sm = 1'b0);
    tbl.push_back('{s, l, c, o, e, sm});
  endfunction

  function automatic int arb(input logic [31:0] v);
    int id = 0;
    int best = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i] && prio[i] > best) begin
        best = prio[i];
        id   = i + 1;
      end
    end
    return id;
  endfunction

  task automatic run(input string nm);
    logic [31:0] act;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      src   = tbl[i].src;
      le    = tbl[i].le;
      claim = tbl[i].cl;
      comp  = tbl[i].co;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      act = tbl[i].sm ? {28'h0, ip_sm} : ip;
      chk($sformatf("%s[%0d]", nm, i), act, exp_q.pop_front());
    end
    tbl.delete();
    claim = '0;
    comp  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src = '0; le = '0; claim = '0; comp = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] L, E, S, I, R, P, A, B;
    L = 32'd1 << 3;
    E = 32'd1 << 5;
    S = 32'd1;
    I = 32'd1 << 1;
    R = 32'd1 << 7;
    P = 32'd1 << 8;
    A = 32'd1 << 10;
    B = 32'd1 << 12;
    for (int i = 0; i < 32; i++) prio[i] = 0;
    prio[10] = 3;
    prio[12] = 5;

    rst_n = 1'b0;
    src = '0; le = '0; claim = '0; comp = '0;
    #1;
    do_reset();
    #1;
    chk("reset_ip", ip, 32'h0);
    chk("reset_ip_sm", {28'h0, ip_sm}, 32'h0);

    // level source: latency, claim, re-raise after complete
    add(L, 0, 0, 0, 0);
    add(L, 0, 0, 0, 0);
    add(L, 0, 0, 0, L);
    add(L, 0, L, 0, 0);
    add(L, 0, 0, 0, 0);
    add(L, 0, 0, L, 0);
    add(L, 0, 0, 0, L);
    add(0, 0, 0, 0, L);
    add(0, 0, L, 0, 0);
    add(0, 0, 0, L, 0);
    add(0, 0, 0, 0, 0);
    run("level");

    // edge queueing: one raise plus three queued edges
    do_reset();
    add(E, E, 0, 0, 0);
    add(0, E, 0, 0, 0);
    add(0, E, 0, 0, E);
    for (int k = 0; k < 3; k++) begin
      add(E, E, 0, 0, E);
      add(0, E, 0, 0, E);
    end
    add(0, E, 0, 0, E);
    for (int k = 0; k < 3; k++) begin
      add(0, E, E, 0, 0);
      add(0, E, 0, E, 0);
      add(0, E, 0, 0, E);
    end
    add(0, E, E, 0, 0);
    add(0, E, 0, E, 0);
    add(0, E, 0, 0, 0);
    add(0, E, 0, 0, 0);
    run("edge_q");

    // saturation on the CNT_W=2 instance
    do_reset();
    add(S, S, 0, 0, 0, 1);
    add(0, S, 0, 0, 0, 1);
    add(0, S, 0, 0, S, 1);
    add(0, S, S, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      add(S, S, 0, 0, 0, 1);
      add(0, S, 0, 0, 0, 1);
    end
    add(0, S, 0, 0, 0, 1);
    add(0, S, 0, S, 0, 1);
    for (int k = 0; k < 3; k++) begin
      add(0, S, 0, 0, S, 1);
      add(0, S, S, 0, 0, 1);
      add(0, S, 0, S, 0, 1);
    end
    add(0, S, 0, 0, 0, 1);
    add(0, S, 0, 0, 0, 1);
    run("sat");

    // illegal and overlapping handshakes
    do_reset();
    add(0, 0, I, I, 0);
    add(I, 0, 0, 0, 0);
    add(I, 0, 0, 0, 0);
    add(I, 0, 0, 0, I);
    add(I, 0, I, 0, 0);
    add(I, 0, I, 0, 0);
    add(I, 0, 0, 0, 0);
    add(I, 0, 0, I, 0);
    add(I, 0, 0, 0, I);
    add(I, 0, 0, I, I);
    add(0, 0, I, I, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, I, 0);
    add(0, 0, 0, 0, 0);
    run("illegal");

    // reset mid-service with queued edges
    do_reset();
    add(R | P, R, 0, 0, 0);
    add(P, R, 0, 0, 0);
    add(P, R, 0, 0, R | P);
    add(P, R, R, 0, P);
    add(R | P, R, 0, 0, P);
    add(P, R, 0, 0, P);
    add(R | P, R, 0, 0, P);
    add(P, R, 0, 0, P);
    add(P, R, 0, 0, P);
    run("rst_pre");
    @(negedge clk);
    rst_n = 1'b0;
    src   = '0;
    #1;
    chk("rst_async_ip", ip, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) add(0, R, 0, 0, 0);
    run("rst_post");

    // two sources in front of a priority arbiter
    do_reset();
    add(A | B, 0, 0, 0, 0);
    add(A | B, 0, 0, 0, 0);
    add(A | B, 0, 0, 0, A | B);
    run("integ");
    chk("integ_id_hi", 32'(arb(ip)), 32'd13);
    add(A | B, 0, B, 0, A);
    run("integ_claim");
    chk("integ_id_lo", 32'(arb(ip)), 32'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
